// File: rtl/puf_challenge_sequencer_if.sv
// ---------------------------------------------------------------------------
// puf_challenge_sequencer_if
// Purpose : valid/ready word channel from the challenge sequencer to the
//           serial transmitter.
// Signals : word_valid  - a finished response word is being offered
//           word_data   - packed response word, first harvested bit in MSB
//           word_ready  - consumer accepts the word this cycle
// Modports: master (sequencer side), slave (consumer side)
// ---------------------------------------------------------------------------
interface puf_challenge_sequencer_if #(
    parameter int RESP_W = 8
);
    logic              word_valid;
    logic [RESP_W-1:0] word_data;
    logic              word_ready;

    modport master (
        output word_valid,
        output word_data,
        input  word_ready
    );

    modport slave (
        input  word_valid,
        input  word_data,
        output word_ready
    );
endinterface

// File: rtl/puf_challenge_sequencer.sv
// ---------------------------------------------------------------------------
// puf_challenge_sequencer
// Purpose : drives a challenge scrambler and a delay-PUF race core to harvest
//           num_words words of RESP_W response bits each. The scrambler is
//           seeded once per run and stepped once per response bit; each
//           challenge is allowed to settle before the PUF is fired.
// Ports   : clock, reset        - system clock, asynchronous active-high reset
//           start_i             - begin a run (only honoured while idle)
//           seed_i, num_words_i - run parameters, latched on an accepted start
//           busy_o, done_o      - run in progress / one-cycle completion pulse
//           err_o               - sticky: some bit of this run timed out
//           scr_*               - scrambler seed, load pulse, step pulse, output
//           puf_*               - PUF challenge, trigger pulse, done, result bit
//           word_if             - valid/ready output word channel (master)
// ---------------------------------------------------------------------------
module puf_challenge_sequencer #(
    parameter int CHALL_W       = 8,
    parameter int RESP_W        = 8,
    parameter int COUNT_W       = 8,
    parameter int SETTLE_CYCLES = 4,
    parameter int TIMEOUT       = 255
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 start_i,
    input  logic [CHALL_W-1:0]   seed_i,
    input  logic [COUNT_W-1:0]   num_words_i,
    output logic                 busy_o,
    output logic                 done_o,
    output logic                 err_o,
    output logic [CHALL_W-1:0]   scr_chall_in_o,
    output logic                 scr_reset_o,
    output logic                 scr_increment_o,
    input  logic [CHALL_W-1:0]   scr_chall_out_i,
    output logic [CHALL_W-1:0]   puf_challenge_o,
    output logic                 puf_trigger_o,
    input  logic                 puf_done_i,
    input  logic                 puf_resp_i,
    puf_challenge_sequencer_if.master word_if
);

    // Down-counters are replaced by up-counters that stop at N-1, so each
    // needs only enough bits to hold N-1.
    localparam int SET_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
    localparam int TMO_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam int BIT_W = (RESP_W > 1) ? $clog2(RESP_W) : 1;

    localparam logic [SET_W-1:0]   SETTLE_LAST = SET_W'(SETTLE_CYCLES - 1);
    localparam logic [TMO_W-1:0]   WAIT_LAST   = TMO_W'(TIMEOUT - 1);
    localparam logic [BIT_W-1:0]   BIT_LAST    = BIT_W'(RESP_W - 1);
    localparam logic [SET_W-1:0]   SET_ONE     = SET_W'(1);
    localparam logic [TMO_W-1:0]   TMO_ONE     = TMO_W'(1);
    localparam logic [BIT_W-1:0]   BIT_ONE     = BIT_W'(1);
    localparam logic [COUNT_W-1:0] CNT_ONE     = COUNT_W'(1);

    typedef enum logic [3:0] {
        S_IDLE, S_LOAD, S_STEP, S_SETTLE, S_FIRE, S_WAIT, S_SHIFT, S_EMIT, S_FIN
    } state_t;

    state_t              state_q,         state_d;
    logic [CHALL_W-1:0]  seed_q,          seed_d;
    logic [COUNT_W-1:0]  num_words_q,     num_words_d;
    logic [COUNT_W-1:0]  word_cnt_q,      word_cnt_d;
    logic [BIT_W-1:0]    bit_cnt_q,       bit_cnt_d;
    logic [SET_W-1:0]    settle_cnt_q,    settle_cnt_d;
    logic [TMO_W-1:0]    wait_cnt_q,      wait_cnt_d;
    logic [RESP_W-1:0]   shreg_q,         shreg_d;
    logic                bit_q,           bit_d;
    logic [RESP_W-1:0]   word_data_q,     word_data_d;
    logic [CHALL_W-1:0]  puf_challenge_q, puf_challenge_d;
    logic                err_q,           err_d;

    logic scr_reset, scr_increment, puf_trigger, word_valid, done;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q         <= S_IDLE;
            seed_q          <= '0;
            num_words_q     <= '0;
            word_cnt_q      <= '0;
            bit_cnt_q       <= '0;
            settle_cnt_q    <= '0;
            wait_cnt_q      <= '0;
            shreg_q         <= '0;
            bit_q           <= 1'b0;
            word_data_q     <= '0;
            puf_challenge_q <= '0;
            err_q           <= 1'b0;
        end else begin
            state_q         <= state_d;
            seed_q          <= seed_d;
            num_words_q     <= num_words_d;
            word_cnt_q      <= word_cnt_d;
            bit_cnt_q       <= bit_cnt_d;
            settle_cnt_q    <= settle_cnt_d;
            wait_cnt_q      <= wait_cnt_d;
            shreg_q         <= shreg_d;
            bit_q           <= bit_d;
            word_data_q     <= word_data_d;
            puf_challenge_q <= puf_challenge_d;
            err_q           <= err_d;
        end
    end

    always_comb begin
        state_d         = state_q;
        seed_d          = seed_q;
        num_words_d     = num_words_q;
        word_cnt_d      = word_cnt_q;
        bit_cnt_d       = bit_cnt_q;
        settle_cnt_d    = settle_cnt_q;
        wait_cnt_d      = wait_cnt_q;
        shreg_d         = shreg_q;
        bit_d           = bit_q;
        word_data_d     = word_data_q;
        puf_challenge_d = puf_challenge_q;
        err_d           = err_q;
        scr_reset       = 1'b0;
        scr_increment   = 1'b0;
        puf_trigger     = 1'b0;
        word_valid      = 1'b0;
        done            = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (start_i) begin
                    seed_d      = seed_i;
                    num_words_d = num_words_i;
                    err_d       = 1'b0;
                    word_cnt_d  = '0;
                    bit_cnt_d   = '0;
                    shreg_d     = '0;
                    state_d     = (num_words_i == '0) ? S_FIN : S_LOAD;
                end
            end
            S_LOAD: begin
                scr_reset = 1'b1;
                state_d   = S_STEP;
            end
            S_STEP: begin
                scr_increment = 1'b1;
                settle_cnt_d  = '0;
                state_d       = S_SETTLE;
            end
            S_SETTLE: begin
                if (settle_cnt_q == SETTLE_LAST) begin
                    // Challenge is frozen here and held until the next settle.
                    puf_challenge_d = scr_chall_out_i;
                    settle_cnt_d    = '0;
                    state_d         = S_FIRE;
                end else begin
                    settle_cnt_d = settle_cnt_q + SET_ONE;
                end
            end
            S_FIRE: begin
                puf_trigger = 1'b1;
                wait_cnt_d  = '0;
                state_d     = S_WAIT;
            end
            S_WAIT: begin
                if (puf_done_i) begin
                    bit_d   = puf_resp_i;
                    state_d = S_SHIFT;
                end else if (wait_cnt_q == WAIT_LAST) begin
                    // PUF never answered: record a 0 and flag the run.
                    bit_d   = 1'b0;
                    err_d   = 1'b1;
                    state_d = S_SHIFT;
                end else begin
                    wait_cnt_d = wait_cnt_q + TMO_ONE;
                end
            end
            S_SHIFT: begin
                shreg_d = {shreg_q[RESP_W-2:0], bit_q};
                if (bit_cnt_q == BIT_LAST) begin
                    word_data_d = {shreg_q[RESP_W-2:0], bit_q};
                    bit_cnt_d   = '0;
                    state_d     = S_EMIT;
                end else begin
                    bit_cnt_d = bit_cnt_q + BIT_ONE;
                    state_d   = S_STEP;
                end
            end
            S_EMIT: begin
                word_valid = 1'b1;
                if (word_if.word_ready) begin
                    word_cnt_d = word_cnt_q + CNT_ONE;
                    // Scrambler keeps its sequence across words: no reload.
                    state_d    = (word_cnt_d == num_words_q) ? S_FIN : S_STEP;
                end
            end
            S_FIN: begin
                done    = 1'b1;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign busy_o             = (state_q != S_IDLE);
    assign done_o             = done;
    assign err_o              = err_q;
    assign scr_chall_in_o     = seed_q;
    assign scr_reset_o        = scr_reset;
    assign scr_increment_o    = scr_increment;
    assign puf_challenge_o    = puf_challenge_q;
    assign puf_trigger_o      = puf_trigger;
    assign word_if.word_valid = word_valid;
    assign word_if.word_data  = word_data_q;

endmodule
